// File: rtl/fbuff_arbiter_if.sv
// fbuff_arbiter_if
//   Requester-side bus of the frame buffer arbiter: one reader (line buffer
//   fill logic) and one writer (pattern/host writer).
//   master modport: used by the requesters (drives req/addr/data).
//   slave modport : used by fbuff_arbiter (drives grants and read return).
//   Signals:
//     rd_req_i, rd_addr_i          read request and row address
//     rd_gnt_o                     read accepted this cycle
//     rd_data_o, rd_valid_o        read return data and its qualifier
//     wr_req_i, wr_addr_i, wr_data_i  write request, row address, row data
//     wr_gnt_o                     write accepted this cycle
interface fbuff_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 60
);
    logic              rd_req_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_gnt_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              wr_req_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_gnt_o;

    modport master (
        output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
        input  rd_gnt_o, rd_data_o, rd_valid_o, wr_gnt_o
    );

    modport slave (
        input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
        output rd_gnt_o, rd_data_o, rd_valid_o, wr_gnt_o
    );
endinterface

// File: rtl/fbuff_arbiter.sv
// fbuff_arbiter
//   Single-port frame buffer arbiter between a reader and a writer. The reader
//   has priority; a writer denied WR_STALL_MAX consecutive cycles is forced
//   through for one cycle. The accepted transfer is registered onto the frame
//   buffer port; read data returns RD_LATENCY cycles after the port enable.
//   Ports:
//     clk, rstn          clock (rising edge), asynchronous active-low reset
//     bus (slave)        requester handshake, see fbuff_arbiter_if
//     fbuff_en_o/we_o    frame buffer port enable / write enable (registered)
//     fbuff_addr_o       frame buffer address (registered)
//     fbuff_data_o       frame buffer write data (registered, loads on writes)
//     fbuff_data_i       frame buffer douta
//   Optional: define FBUFF_ARB_STATS_EN to add rd_cnt_o, wr_cnt_o and
//   force_cnt_o (32-bit wrapping counts of accepted reads, accepted writes
//   and forced write grants).
module fbuff_arbiter #(
    parameter int unsigned FBUFF_ADDR_WIDTH = 12,
    parameter int unsigned FBUFF_DATA_WIDTH = 60,
    parameter int unsigned RD_LATENCY       = 1,
    parameter int unsigned WR_STALL_MAX     = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    fbuff_arbiter_if.slave              bus,
    output logic                        fbuff_en_o,
    output logic                        fbuff_we_o,
    output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
    output logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_o,
    input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_i
`ifdef FBUFF_ARB_STATS_EN
    ,
    output logic [31:0]                 rd_cnt_o,
    output logic [31:0]                 wr_cnt_o,
    output logic [31:0]                 force_cnt_o
`endif
);

    localparam logic [7:0] STALL_MAX = 8'(WR_STALL_MAX);

    logic                        rd_gnt;
    logic                        wr_gnt;
    logic                        wr_force;
    logic [7:0]                  stall_cnt;
    logic [RD_LATENCY-1:0]       vld_pipe;
    logic                        rd_issue;
    logic                        rd_ret;
    logic [FBUFF_DATA_WIDTH-1:0] rd_data_hold;

    // Arbitration. Grants are gated by rstn so nothing is accepted in reset.
    always_comb begin
        wr_force = bus.wr_req_i && (stall_cnt == STALL_MAX);
        rd_gnt   = 1'b0;
        wr_gnt   = 1'b0;
        if (rstn) begin
            wr_gnt = bus.wr_req_i && (!bus.rd_req_i || wr_force);
            rd_gnt = bus.rd_req_i && !wr_force;
        end
    end

    assign bus.rd_gnt_o = rd_gnt;
    assign bus.wr_gnt_o = wr_gnt;

    // Consecutive denied-write counter; saturates at STALL_MAX because the
    // write is always granted once the count gets there.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (bus.wr_req_i && !wr_gnt) begin
            stall_cnt <= stall_cnt + 8'd1;
        end else begin
            stall_cnt <= '0;
        end
    end

    // Frame buffer port: one registered transfer per accept, idle otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fbuff_en_o   <= 1'b0;
            fbuff_we_o   <= 1'b0;
            fbuff_addr_o <= '0;
            fbuff_data_o <= '0;
        end else begin
            fbuff_en_o <= rd_gnt || wr_gnt;
            fbuff_we_o <= wr_gnt;
            if (wr_gnt) begin
                fbuff_addr_o <= bus.wr_addr_i;
                fbuff_data_o <= bus.wr_data_i;
            end else if (rd_gnt) begin
                fbuff_addr_o <= bus.rd_addr_i;
            end
        end
    end

    // Valid pipeline tracks each read from port enable to douta. It follows
    // the port itself, so a write issued right behind a read never shifts or
    // masks that read's return slot.
    assign rd_issue = fbuff_en_o && !fbuff_we_o;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_issue;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign rd_ret = vld_pipe[RD_LATENCY-1];

    // Return data is passed straight from douta in the valid cycle and held
    // afterwards, so rd_data_o is stable whenever rd_valid_o is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_hold <= '0;
        end else if (rd_ret) begin
            rd_data_hold <= fbuff_data_i;
        end
    end

    assign bus.rd_valid_o = rd_ret;
    assign bus.rd_data_o  = rd_ret ? fbuff_data_i : rd_data_hold;

`ifdef FBUFF_ARB_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_cnt_o    <= '0;
            wr_cnt_o    <= '0;
            force_cnt_o <= '0;
        end else begin
            if (rd_gnt) begin
                rd_cnt_o <= rd_cnt_o + 32'd1;
            end
            if (wr_gnt) begin
                wr_cnt_o <= wr_cnt_o + 32'd1;
            end
            if (wr_gnt && wr_force) begin
                force_cnt_o <= force_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fbuff_arbiter.sv
module tb_fbuff_arbiter;

    localparam int unsigned AW  = 12;
    localparam int unsigned DW  = 60;
    localparam int unsigned LAT = 1;
    localparam int unsigned SMX = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          fbuff_en, fbuff_we;
    logic [AW-1:0] fbuff_addr;
    logic [DW-1:0] fbuff_dout;
    logic [DW-1:0] douta = '0;
`ifdef FBUFF_ARB_STATS_EN
    logic [31:0]   rd_cnt, wr_cnt, force_cnt;
    int            m_rd_cnt = 0, m_wr_cnt = 0, m_force_cnt = 0;
`endif

    fbuff_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fbuff_arbiter #(
        .FBUFF_ADDR_WIDTH(AW),
        .FBUFF_DATA_WIDTH(DW),
        .RD_LATENCY      (LAT),
        .WR_STALL_MAX    (SMX)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus.slave),
        .fbuff_en_o  (fbuff_en),
        .fbuff_we_o  (fbuff_we),
        .fbuff_addr_o(fbuff_addr),
        .fbuff_data_o(fbuff_dout),
        .fbuff_data_i(douta)
`ifdef FBUFF_ARB_STATS_EN
        ,
        .rd_cnt_o    (rd_cnt),
        .wr_cnt_o    (wr_cnt),
        .force_cnt_o (force_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Row contents of the frame buffer as seen by reads: a fixed function of
    // the address. Non-read cycles put noise on douta.
    function automatic logic [DW-1:0] row(input logic [AW-1:0] a);
        return {a, ~a, a ^ 12'h5A5, a + 12'd7, a ^ 12'hC3C};
    endfunction

    always @(posedge clk) begin
        if (fbuff_en && !fbuff_we) douta <= row(fbuff_addr);
        else                       douta <= DW'({$urandom(), $urandom()});
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: consecutive writer denials, expected port
    // contents, and outstanding read returns keyed by cycle number.
    typedef struct { int due; logic [DW-1:0] d; } ret_t;
    ret_t          retq[$];
    int            cyc = 0;
    int            denied = 0;
    logic          e_en = 0, e_we = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [DW-1:0] e_rdata = '0;

    // One clock: apply requests (caller is at a negedge), check grants,
    // advance the model, then check the registered outputs at the next negedge.
    task automatic step(input logic r, input logic [AW-1:0] ra,
                        input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        output logic rg, output logic wg);
        logic frc;
        bus.rd_req_i  = r;
        bus.rd_addr_i = ra;
        bus.wr_req_i  = w;
        bus.wr_addr_i = wa;
        bus.wr_data_i = wd;
        #1;
        frc = w && (denied == SMX);
        wg  = w && (!r || frc);
        rg  = r && !frc;
        check("rd_gnt", 64'(bus.rd_gnt_o), 64'(rg));
        check("wr_gnt", 64'(bus.wr_gnt_o), 64'(wg));
        denied = (w && !wg) ? denied + 1 : 0;
        e_en = rg || wg;
        e_we = wg;
        if (wg) begin
            e_addr  = wa;
            e_wdata = wd;
        end else if (rg) begin
            e_addr = ra;
            retq.push_back('{cyc + 1 + int'(LAT), row(ra)});
        end
`ifdef FBUFF_ARB_STATS_EN
        if (rg) m_rd_cnt++;
        if (wg) m_wr_cnt++;
        if (wg && frc) m_force_cnt++;
`endif
        @(negedge clk);
        cyc++;
        check("fbuff_en", 64'(fbuff_en), 64'(e_en));
        check("fbuff_we", 64'(fbuff_we), 64'(e_we));
        if (e_en) check("fbuff_addr", 64'(fbuff_addr), 64'(e_addr));
        check("fbuff_data", 64'(fbuff_dout), 64'(e_wdata));
        if (retq.size() > 0 && retq[0].due == cyc) begin
            e_rdata = retq[0].d;
            void'(retq.pop_front());
            check("rd_valid", 64'(bus.rd_valid_o), 64'd1);
        end else begin
            check("rd_valid", 64'(bus.rd_valid_o), 64'd0);
        end
        check("rd_data", 64'(bus.rd_data_o), 64'(e_rdata));
    endtask

    initial begin : main
        logic rg, wg, rr, ww, rh, wh;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd;
        int nw, first;

        bus.rd_req_i = 0; bus.rd_addr_i = '0;
        bus.wr_req_i = 0; bus.wr_addr_i = '0; bus.wr_data_i = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt", 64'({bus.rd_gnt_o, bus.wr_gnt_o}), 64'd0);
        check("rst_port", 64'({fbuff_en, fbuff_we}), 64'd0);
        check("rst_addr", 64'(fbuff_addr), 64'd0);
        check("rst_valid", 64'(bus.rd_valid_o), 64'd0);
        check("rst_rdata", 64'(bus.rd_data_o), 64'd0);
        rstn = 1;
        @(negedge clk);

        // Single read, then single write of all-ones to the top row
        step(1, 12'h005, 0, '0, '0, rg, wg);
        check("single_rd_gnt", 64'(rg), 64'd1);
        step(0, '0, 0, '0, '0, rg, wg);
        check("single_rd_port", 64'({fbuff_en, fbuff_we}), 64'b00);
        step(0, '0, 1, 12'hEFF, '1, rg, wg);
        step(0, '0, 0, '0, '0, rg, wg);
        repeat (3) step(0, '0, 0, '0, '0, rg, wg);

        // Eight back-to-back reads, addresses 0..7
        for (int i = 0; i < 8; i++) step(1, AW'(i), 0, '0, '0, rg, wg);
        repeat (3) step(0, '0, 0, '0, '0, rg, wg);

        // Both requesters saturated: 16 reads then one forced write, twice
        nw = 0; first = -1;
        for (int i = 0; i < 34; i++) begin
            step(1, AW'(i), 1, 12'h100, DW'(64'hABC), rg, wg);
            if (wg) begin nw++; if (first < 0) first = i; end
        end
        check("sat_writes", 64'(nw), 64'd2);
        check("sat_first_force", 64'(first), 64'(SMX));
        repeat (3) step(0, '0, 0, '0, '0, rg, wg);

        // Writer drops after 10 denials, re-raises: full window again
        for (int i = 0; i < 10; i++) step(1, AW'(i), 1, 12'h200, DW'(64'h55), rg, wg);
        step(1, 12'h00A, 0, '0, '0, rg, wg);
        first = -1;
        for (int i = 0; i < 20 && first < 0; i++) begin
            step(1, AW'(i), 1, 12'h201, DW'(64'h66), rg, wg);
            if (wg) first = i;
        end
        check("restart_force", 64'(first), 64'(SMX));
        repeat (3) step(0, '0, 0, '0, '0, rg, wg);

        // Reset with three reads in flight
        for (int i = 0; i < 3; i++) step(1, AW'(i + 40), 0, '0, '0, rg, wg);
        bus.rd_req_i = 1; bus.wr_req_i = 1;
        rstn = 0;
        #1;
        check("rst_mid_gnt", 64'({bus.rd_gnt_o, bus.wr_gnt_o}), 64'd0);
        check("rst_mid_port", 64'({fbuff_en, fbuff_we}), 64'd0);
        check("rst_mid_addr", 64'(fbuff_addr), 64'd0);
        check("rst_mid_wdata", 64'(fbuff_dout), 64'd0);
        check("rst_mid_valid", 64'(bus.rd_valid_o), 64'd0);
        check("rst_mid_rdata", 64'(bus.rd_data_o), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1;
        retq.delete();
        denied = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
`ifdef FBUFF_ARB_STATS_EN
        m_rd_cnt = 0; m_wr_cnt = 0; m_force_cnt = 0;
`endif
        step(1, 12'h077, 0, '0, '0, rg, wg);
        check("post_rst_gnt", 64'(rg), 64'd1);
        repeat (3) step(0, '0, 0, '0, '0, rg, wg);

        // Random traffic; requests and payloads are held while ungranted
        rh = 0; wh = 0; rr = 0; ww = 0; ra = '0; wa = '0; wd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!rh) begin rr = ($urandom_range(0, 3) != 0); ra = AW'($urandom()); end
            if (!wh) begin ww = $urandom_range(0, 1) == 1; wa = AW'($urandom());
                           wd = DW'({$urandom(), $urandom()}); end
            step(rr, ra, ww, wa, wd, rg, wg);
            rh = rr && !rg;
            wh = ww && !wg;
        end
        repeat (4) step(0, '0, 0, '0, '0, rg, wg);
        check("drained", 64'(retq.size()), 64'd0);

`ifdef FBUFF_ARB_STATS_EN
        check("rd_cnt", 64'(rd_cnt), 64'(m_rd_cnt));
        check("wr_cnt", 64'(wr_cnt), 64'(m_wr_cnt));
        check("force_cnt", 64'(force_cnt), 64'(m_force_cnt));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fbuff_arbiter.md
FBUFF_ARBITER -- requirements
Module: fbuff_arbiter

Interface
REQ-001 Parameter FBUFF_ADDR_WIDTH, default 12: frame buffer address width (3840 rows).
REQ-002 Parameter FBUFF_DATA_WIDTH, default 60: frame buffer row width (5 tiles x 12 bits).
REQ-003 Parameter RD_LATENCY, default 1: frame buffer read latency in cycles, from port enable to douta valid, range 1..4.
REQ-004 Parameter WR_STALL_MAX, default 16: number of consecutive denied writer cycles before the writer is forced through, range 1..255.
REQ-005 clk  in  1  clock; all logic is on the rising edge.
REQ-006 rstn  in  1  reset; asynchronous, active-low.
REQ-007 rd_req_i  in  1  read request from the line buffer fill logic.
REQ-008 rd_addr_i  in  FBUFF_ADDR_WIDTH  read row address; held stable while rd_req_i is high and ungranted.
REQ-009 rd_gnt_o  out  1  read accepted this cycle (combinational).
REQ-010 rd_data_o  out  FBUFF_DATA_WIDTH  read data, qualified by rd_valid_o.
REQ-011 rd_valid_o  out  1  one-cycle pulse per accepted read.
REQ-012 wr_req_i  in  1  write request from the pattern/host writer.
REQ-013 wr_addr_i / wr_data_i  in  FBUFF_ADDR_WIDTH / FBUFF_DATA_WIDTH  write address and data; held stable until granted.
REQ-014 wr_gnt_o  out  1  write accepted this cycle (combinational).
REQ-015 fbuff_en_o, fbuff_we_o  out  1 each  frame buffer port enable and write enable (registered).
REQ-016 fbuff_addr_o / fbuff_data_o  out  FBUFF_ADDR_WIDTH / FBUFF_DATA_WIDTH  frame buffer address and write data (registered).
REQ-017 fbuff_data_i  in  FBUFF_DATA_WIDTH  frame buffer douta.

Function
REQ-018 A transfer is accepted in a cycle where req and gnt are both high at the rising edge; at most one grant per cycle.
REQ-019 Arbitration: the reader has priority; the writer is granted when rd_req_i is low, or when stall_cnt == WR_STALL_MAX.
REQ-020 stall_cnt (8 bits) increments each cycle wr_req_i is high and wr_gnt_o is low, and clears on a write grant or when wr_req_i is low; it never exceeds WR_STALL_MAX.
REQ-021 When a forced write is granted, rd_gnt_o is low that cycle, and the read stays pending.
REQ-022 The accepted transfer drives the fbuff port in the next cycle: en=1, we=1 for a write or 0 for a read, with addr and data captured; the port is idle (en=0, we=0) in cycles after no accept.
REQ-023 Read data: rd_valid_o pulses exactly RD_LATENCY cycles after fbuff_en_o asserts for that read, with rd_data_o = fbuff_data_i in that cycle; the total accept-to-valid latency is 1+RD_LATENCY.
REQ-024 Back-to-back reads are accepted every cycle at full throughput, and rd_valid_o returns them in the order accepted.
REQ-025 A write accepted the cycle after a read does not disturb that read's rd_valid_o pulse or rd_data_o.
REQ-026 rd_data_o holds its last value when rd_valid_o is low.

Reset
REQ-027 On rstn low: rd_valid_o=0, fbuff_en_o=0, fbuff_we_o=0, fbuff_addr_o=0, fbuff_data_o=0, rd_data_o=0, stall_cnt=0, and the valid pipeline clears.
REQ-028 Reads in flight at reset are dropped; no rd_valid_o pulse occurs for them after reset release.
REQ-029 Grants are forced low while rstn is low.

Configuration
REQ-030 Macro FBUFF_ARB_STATS_EN: when defined, the block adds 32-bit outputs rd_cnt_o, wr_cnt_o and force_cnt_o.
REQ-031 rd_cnt_o counts accepted reads, wr_cnt_o counts accepted writes, and force_cnt_o counts forced write grants; all three wrap modulo 2^32 and reset to 0.
REQ-032 When FBUFF_ARB_STATS_EN is undefined, these ports and counters are absent and all other behaviour is identical.

Verification
REQ-033 Single read, addr 0x005, RD_LATENCY=1, fbuff_data_i=0x123... -> rd_gnt_o=1 in cycle N; fbuff_en_o=1, we=0, addr 0x005 in N+1; rd_valid_o=1 with that data in N+2.
REQ-034 Write only, addr 0xEFF, data all-ones -> wr_gnt_o=1 in N; fbuff_en_o=1, fbuff_we_o=1, addr 0xEFF, data all-ones in N+1; no rd_valid_o.
REQ-035 rd_req_i and wr_req_i held continuously high, WR_STALL_MAX=16 -> 16 reads granted, then exactly 1 write, repeating; stall_cnt peaks at 16; force_cnt_o increments once per 17 cycles when the macro is defined.
REQ-036 8 consecutive reads at addrs 0..7 -> 8 rd_valid_o pulses in consecutive cycles, in order, each 2 cycles after its accept (RD_LATENCY=1), and 4 cycles after its accept with RD_LATENCY=3.
REQ-037 rstn asserted one cycle after 3 reads are accepted -> all outputs go to reset values immediately; zero rd_valid_o pulses after release; the first request after release is granted normally.
REQ-038 wr_req_i dropped after 10 denied cycles, then re-raised -> stall_cnt restarts from 0, and no forced grant occurs until 16 further denied cycles.
